// File: rtl/trig_ctrl.sv
// Multi-channel trigger controller: per-channel qualification filters, pending
// capture with miss counting, and round-robin arbitration onto one pulse output.
module trig_ctrl #(
    parameter  int NCH = 4,
    parameter  int CW  = 16,
    localparam int SW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           C,
    input  logic           RN,
    input  logic [NCH-1:0] TRIG_IN,
    input  logic [NCH-1:0] EN,
    input  logic [CW-1:0]  FILT_LEN,
    input  logic [CW-1:0]  PW,
    input  logic [CW-1:0]  HOLDOFF,
    input  logic           ARM,
    input  logic           DISARM,
    input  logic           ONESHOT,
    output logic           TRIG_OUT,
    output logic [SW-1:0]  SRC,
    output logic           BUSY,
    output logic           ARMED,
    output logic [7:0]     MISS_CNT
);

    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_HOLD} state_t;

    function automatic logic [3:0] pop_count(input logic [NCH-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NCH; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'b00000, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    state_t         state;
    logic [CW-1:0]  filt_cnt [NCH];
    logic [NCH-1:0] qual, qual_p1, evt, pend, pend_nxt, miss, gnt_mask;
    logic [SW-1:0]  rr_ptr, gnt_idx, idx;
    logic [SW:0]    sum;
    logic           gnt_any, accept;
    logic [CW-1:0]  tmr, hold_lat;

    always_comb begin
        qual = '0;
        for (int i = 0; i < NCH; i++)
            qual[i] = TRIG_IN[i] & EN[i] & (filt_cnt[i] == FILT_LEN);
    end

    // One event per qualified assertion: only the rising edge of qual counts.
    assign evt = qual & ~qual_p1;

    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        gnt_mask = '0;
        idx      = '0;
        sum      = '0;
        if (state == ST_IDLE && ARMED) begin
            for (int off = 0; off < NCH; off++) begin
                sum = {1'b0, rr_ptr} + (SW+1)'(off);
                if (sum >= (SW+1)'(NCH)) sum = sum - (SW+1)'(NCH);
                idx = sum[SW-1:0];
                if (!gnt_any && pend[idx]) begin
                    gnt_any       = 1'b1;
                    gnt_idx       = idx;
                    gnt_mask[idx] = 1'b1;
                end
            end
        end
    end

    // A one-shot grant disarms in the same cycle, so its coincident events are lost.
    assign accept   = ARMED & ~DISARM & ~(gnt_any & ONESHOT);
    assign miss     = accept ? (evt & pend & ~gnt_mask) : '0;
    assign pend_nxt = DISARM ? '0 : (((pend & ~gnt_mask) | (accept ? evt : '0)) & EN);

    // Stage p1: filter counters and registered qualification.
    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            qual_p1 <= '0;
            for (int i = 0; i < NCH; i++) filt_cnt[i] <= '0;
        end else begin
            qual_p1 <= qual;
            for (int i = 0; i < NCH; i++) begin
                if (!TRIG_IN[i] || !EN[i])      filt_cnt[i] <= '0;
                else if (filt_cnt[i] >= FILT_LEN) filt_cnt[i] <= FILT_LEN;
                else                              filt_cnt[i] <= filt_cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            pend     <= '0;
            MISS_CNT <= '0;
            ARMED    <= 1'b0;
        end else begin
            pend     <= pend_nxt;
            MISS_CNT <= sat_add8(MISS_CNT, pop_count(miss));
            if (DISARM)                 ARMED <= 1'b0;
            else if (gnt_any && ONESHOT) ARMED <= 1'b0;
            else if (ARM)               ARMED <= 1'b1;
        end
    end

    // Pulse/holdoff sequencer; PW and HOLDOFF are captured only at grant.
    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state    <= ST_IDLE;
            TRIG_OUT <= 1'b0;
            BUSY     <= 1'b0;
            SRC      <= '0;
            rr_ptr   <= '0;
            tmr      <= '0;
            hold_lat <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        state    <= ST_PULSE;
                        TRIG_OUT <= 1'b1;
                        BUSY     <= 1'b1;
                        SRC      <= gnt_idx;
                        rr_ptr   <= (gnt_idx == SW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
                        tmr      <= (PW == '0) ? CW'(1) : PW;
                        hold_lat <= HOLDOFF;
                    end
                end
                ST_PULSE: begin
                    if (tmr <= CW'(1)) begin
                        TRIG_OUT <= 1'b0;
                        if (hold_lat == '0) begin
                            state <= ST_IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            state <= ST_HOLD;
                            tmr   <= hold_lat;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (tmr <= CW'(1)) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    TRIG_OUT <= 1'b0;
                    BUSY     <= 1'b0;
                end
            endcase
        end
    end

endmodule
